// File: rtl/ddr4_bg_sched.sv
// ddr4_bg_sched: per-bank-group request scheduler for a single DDR4 command bus.
// Requests enter on one valid/ready port and are sorted into a FIFO per bank
// group. One open bank/row is tracked per group; groups are served round-robin
// and each request becomes PRE/ACT/RD/WR with programmable tRP/tRCD/CL/CWL.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake (ready is combinational)
//   req_write/req_addr/wdata   request: addr = {row, bg, ba[1:0], col}
//   rsp_valid/rsp_rdata/rsp_bg read return with bank-group tag
//   busy                       FSM active or any queue non-empty
//   ddr4_cs_n..ddr4_we_n       command pins (registered)
//   ddr4_addr/ddr4_ba/ddr4_bg  command address (registered)
//   ddr4_dq_out/ddr4_dq_oe     write data path
//   ddr4_dq_in                 read data from the device
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for a non-empty queue; grant + pop
// PRE      | PRE on the bus for the group's open bank
// WAIT_RP  | counting tRP toward ACT
// ACT      | ACT on the bus; open bank/row recorded
// WAIT_RCD | counting tRCD toward RD/WR
// CAS      | RD or WR on the bus
// The state register names the command visible on the bus in that cycle.

module ddr4_bg_sched #(
  parameter int NUM_BG = 4,
  parameter int DEPTH  = 4,
  parameter int COL_W  = 10,
  parameter int ROW_W  = 16,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16,
  parameter int T_RP   = 3,
  parameter int T_RCD  = 3,
  parameter int T_CL   = 5,
  parameter int T_CWL  = 4,
  localparam int BG_W  = (NUM_BG > 1) ? $clog2(NUM_BG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [BG_W-1:0]   rsp_bg,
  output logic              busy,
  output logic              ddr4_cs_n,
  output logic              ddr4_ras_n,
  output logic              ddr4_cas_n,
  output logic              ddr4_we_n,
  output logic [ROW_W-1:0]  ddr4_addr,
  output logic [1:0]        ddr4_ba,
  output logic [BG_W-1:0]   ddr4_bg,
  output logic [DATA_W-1:0] ddr4_dq_out,
  output logic              ddr4_dq_oe,
  input  logic [DATA_W-1:0] ddr4_dq_in
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int USED_W = COL_W + 2 + BG_W + ROW_W;
  localparam int T_MAX  = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int TMR_W  = $clog2(T_MAX);

  localparam logic [3:0] CMD_NOP = 4'b1111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_CAS} state_t;

  // request decode
  logic [COL_W-1:0] req_col;
  logic [1:0]       req_ba;
  logic [BG_W-1:0]  req_bg;
  logic [ROW_W-1:0] req_row;
  logic             bg_ok, push;

  assign req_col = req_addr[COL_W-1:0];
  assign req_ba  = req_addr[COL_W+1:COL_W];
  assign req_bg  = req_addr[COL_W+2 +: BG_W];
  assign req_row = req_addr[COL_W+2+BG_W +: ROW_W];
  assign bg_ok   = (int'(req_bg) < NUM_BG);

  generate
    if (ADDR_W > USED_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^req_addr[ADDR_W-1:USED_W];
    end
  endgenerate

  // per-group queues
  logic              q_write [NUM_BG][DEPTH];
  logic [1:0]        q_ba    [NUM_BG][DEPTH];
  logic [ROW_W-1:0]  q_row   [NUM_BG][DEPTH];
  logic [COL_W-1:0]  q_col   [NUM_BG][DEPTH];
  logic [DATA_W-1:0] q_wdata [NUM_BG][DEPTH];
  logic [PTR_W:0]    q_wp    [NUM_BG];
  logic [PTR_W:0]    q_rp    [NUM_BG];
  logic [NUM_BG-1:0] q_empty, q_full;

  always_comb begin
    for (int g = 0; g < NUM_BG; g++) begin
      q_empty[g] = (q_wp[g] == q_rp[g]);
      q_full[g]  = (q_wp[g][PTR_W] != q_rp[g][PTR_W]) &&
                   (q_wp[g][PTR_W-1:0] == q_rp[g][PTR_W-1:0]);
    end
  end

  // out-of-range groups never match, so they are accepted and dropped
  always_comb begin
    req_ready = 1'b1;
    for (int g = 0; g < NUM_BG; g++)
      if (req_bg == BG_W'(g)) req_ready = !q_full[g];
  end

  assign push = req_valid && req_ready && bg_ok;

  always_ff @(posedge clk) begin
    if (push) begin
      q_write[req_bg][q_wp[req_bg][PTR_W-1:0]] <= req_write;
      q_ba   [req_bg][q_wp[req_bg][PTR_W-1:0]] <= req_ba;
      q_row  [req_bg][q_wp[req_bg][PTR_W-1:0]] <= req_row;
      q_col  [req_bg][q_wp[req_bg][PTR_W-1:0]] <= req_col;
      q_wdata[req_bg][q_wp[req_bg][PTR_W-1:0]] <= req_wdata;
    end
  end

  // round-robin grant: lowest offset from rr_ptr wins (loop runs downward)
  state_t           state;
  logic [BG_W-1:0]  rr_ptr, grant_bg, rr_idx;
  logic             grant_any, pop;

  always_comb begin
    grant_any = 1'b0;
    grant_bg  = '0;
    rr_idx    = '0;
    for (int i = NUM_BG - 1; i >= 0; i--) begin
      rr_idx = BG_W'((int'(rr_ptr) + i) % NUM_BG);
      if (!q_empty[rr_idx]) begin
        grant_any = 1'b1;
        grant_bg  = rr_idx;
      end
    end
  end

  assign pop = (state == S_IDLE) && grant_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NUM_BG; g++) begin
        q_wp[g] <= '0;
        q_rp[g] <= '0;
      end
    end else begin
      for (int g = 0; g < NUM_BG; g++) begin
        if (push && req_bg == BG_W'(g)) q_wp[g] <= q_wp[g] + 1'b1;
        if (pop && grant_bg == BG_W'(g)) q_rp[g] <= q_rp[g] + 1'b1;
      end
    end
  end

  // head of the granted queue and row-hit test
  logic [PTR_W-1:0]  hd_idx;
  logic              hd_write, hit;
  logic [1:0]        hd_ba;
  logic [ROW_W-1:0]  hd_row;
  logic [COL_W-1:0]  hd_col;
  logic [DATA_W-1:0] hd_wdata;
  logic [NUM_BG-1:0] open_vld;
  logic [1:0]        open_ba  [NUM_BG];
  logic [ROW_W-1:0]  open_row [NUM_BG];

  assign hd_idx   = q_rp[grant_bg][PTR_W-1:0];
  assign hd_write = q_write[grant_bg][hd_idx];
  assign hd_ba    = q_ba[grant_bg][hd_idx];
  assign hd_row   = q_row[grant_bg][hd_idx];
  assign hd_col   = q_col[grant_bg][hd_idx];
  assign hd_wdata = q_wdata[grant_bg][hd_idx];
  assign hit      = open_vld[grant_bg] && (open_ba[grant_bg] == hd_ba) &&
                    (open_row[grant_bg] == hd_row);

  // command FSM
  logic [3:0]        cmd_q;
  logic [TMR_W-1:0]  tmr;
  logic              cur_write;
  logic [1:0]        cur_ba;
  logic [ROW_W-1:0]  cur_row;
  logic [COL_W-1:0]  cur_col;
  logic [DATA_W-1:0] cur_wdata;
  logic [BG_W-1:0]   cur_bg;

  assign {ddr4_cs_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n} = cmd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_q     <= CMD_NOP;
      ddr4_addr <= '0;
      ddr4_ba   <= '0;
      ddr4_bg   <= '0;
      tmr       <= '0;
      rr_ptr    <= '0;
      cur_write <= 1'b0;
      cur_ba    <= '0;
      cur_row   <= '0;
      cur_col   <= '0;
      cur_wdata <= '0;
      cur_bg    <= '0;
      open_vld  <= '0;
      for (int g = 0; g < NUM_BG; g++) begin
        open_ba[g]  <= '0;
        open_row[g] <= '0;
      end
    end else begin
      cmd_q <= CMD_NOP;
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            cur_write <= hd_write;
            cur_ba    <= hd_ba;
            cur_row   <= hd_row;
            cur_col   <= hd_col;
            cur_wdata <= hd_wdata;
            cur_bg    <= grant_bg;
            rr_ptr    <= BG_W'((int'(grant_bg) + 1) % NUM_BG);
            ddr4_bg   <= grant_bg;
            if (hit) begin
              state     <= S_CAS;
              cmd_q     <= hd_write ? CMD_WR : CMD_RD;
              ddr4_addr <= ROW_W'(hd_col);
              ddr4_ba   <= hd_ba;
            end else if (!open_vld[grant_bg]) begin
              state              <= S_ACT;
              cmd_q              <= CMD_ACT;
              ddr4_addr          <= hd_row;
              ddr4_ba            <= hd_ba;
              open_vld[grant_bg] <= 1'b1;
              open_ba[grant_bg]  <= hd_ba;
              open_row[grant_bg] <= hd_row;
            end else begin
              state              <= S_PRE;
              cmd_q              <= CMD_PRE;
              ddr4_addr          <= '0;
              ddr4_ba            <= open_ba[grant_bg];
              open_vld[grant_bg] <= 1'b0;
            end
          end
        end
        S_PRE: begin
          state <= S_WAIT_RP;
          tmr   <= TMR_W'(T_RP - 2);
        end
        S_WAIT_RP: begin
          if (tmr == '0) begin
            state            <= S_ACT;
            cmd_q            <= CMD_ACT;
            ddr4_addr        <= cur_row;
            ddr4_ba          <= cur_ba;
            ddr4_bg          <= cur_bg;
            open_vld[cur_bg] <= 1'b1;
            open_ba[cur_bg]  <= cur_ba;
            open_row[cur_bg] <= cur_row;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_ACT: begin
          state <= S_WAIT_RCD;
          tmr   <= TMR_W'(T_RCD - 2);
        end
        S_WAIT_RCD: begin
          if (tmr == '0) begin
            state     <= S_CAS;
            cmd_q     <= cur_write ? CMD_WR : CMD_RD;
            ddr4_addr <= ROW_W'(cur_col);
            ddr4_ba   <= cur_ba;
            ddr4_bg   <= cur_bg;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_CAS:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // read-tag and write-data pipelines; stage 0 is loaded while CAS is on the bus
  logic              cas_rd, cas_wr;
  logic [T_CL-1:0]   rd_v;
  logic [BG_W-1:0]   rd_bg [T_CL];
  logic [T_CWL-1:0]  wr_v;
  logic [DATA_W-1:0] wr_d  [T_CWL];

  assign cas_rd = (state == S_CAS) && !cur_write;
  assign cas_wr = (state == S_CAS) && cur_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v <= '0;
      wr_v <= '0;
      for (int i = 0; i < T_CL; i++)  rd_bg[i] <= '0;
      for (int i = 0; i < T_CWL; i++) wr_d[i]  <= '0;
    end else begin
      rd_v[0]  <= cas_rd;
      rd_bg[0] <= cas_rd ? cur_bg : '0;
      for (int i = 1; i < T_CL; i++) begin
        rd_v[i]  <= rd_v[i-1];
        rd_bg[i] <= rd_bg[i-1];
      end
      wr_v[0] <= cas_wr;
      wr_d[0] <= cas_wr ? cur_wdata : '0;
      for (int i = 1; i < T_CWL; i++) begin
        wr_v[i] <= wr_v[i-1];
        wr_d[i] <= wr_d[i-1];
      end
    end
  end

  // read data is taken from the pins during the capture cycle itself
  assign rsp_valid   = rd_v[T_CL-1];
  assign rsp_bg      = rd_bg[T_CL-1];
  assign rsp_rdata   = rsp_valid ? ddr4_dq_in : '0;
  assign ddr4_dq_oe  = wr_v[T_CWL-1];
  assign ddr4_dq_out = wr_d[T_CWL-1];
  assign busy        = (state != S_IDLE) || !(&q_empty);

endmodule

// File: tb/tb_ddr4_bg_sched.sv
module tb_ddr4_bg_sched;
  localparam int NUM_BG = 4, DEPTH = 4, T_RP = 3, T_RCD = 3, T_CL = 5, T_CWL = 4;
  localparam logic [3:0] C_NOP = 4'hF, C_ACT = 4'h3, C_RD = 4'h5, C_WR = 4'h4, C_PRE = 4'h2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [15:0] req_wdata = '0, rsp_rdata, ddr4_dq_out, ddr4_dq_in = '0;
  logic        rsp_valid, busy, ddr4_cs_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n, ddr4_dq_oe;
  logic [1:0]  rsp_bg, ddr4_ba, ddr4_bg;
  logic [15:0] ddr4_addr;

  always #5 clk = ~clk;

  ddr4_bg_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_bg(rsp_bg), .busy(busy),
    .ddr4_cs_n(ddr4_cs_n), .ddr4_ras_n(ddr4_ras_n), .ddr4_cas_n(ddr4_cas_n),
    .ddr4_we_n(ddr4_we_n), .ddr4_addr(ddr4_addr), .ddr4_ba(ddr4_ba), .ddr4_bg(ddr4_bg),
    .ddr4_dq_out(ddr4_dq_out), .ddr4_dq_oe(ddr4_dq_oe), .ddr4_dq_in(ddr4_dq_in)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: per-group FIFOs plus an absolute-cycle command schedule
  typedef struct {
    bit        wr;
    bit [1:0]  ba;
    bit [15:0] row;
    bit [9:0]  col;
    bit [15:0] wd;
  } req_t;

  req_t        mq [NUM_BG][$];
  logic [3:0]  exp_cmd  [int];
  logic [15:0] exp_addr [int];
  logic [1:0]  exp_ba   [int];
  logic [1:0]  exp_bg   [int];
  logic [15:0] exp_wd   [int];
  logic [1:0]  exp_tag  [int];
  bit          open_v   [NUM_BG];
  logic [1:0]  open_ba  [NUM_BG];
  logic [15:0] open_row [NUM_BG];
  int          n, free_at, rr, last_act;

  task automatic model_reset();
    exp_cmd.delete(); exp_addr.delete(); exp_ba.delete(); exp_bg.delete();
    exp_wd.delete(); exp_tag.delete();
    for (int g = 0; g < NUM_BG; g++) begin
      mq[g].delete();
      open_v[g] = 1'b0;
    end
    free_at = 0; rr = 0; last_act = -1;
  endtask

  task automatic sched(input int t, input logic [3:0] c, input logic [15:0] a,
                       input logic [1:0] ba, input int g);
    exp_cmd[t] = c; exp_addr[t] = a; exp_ba[t] = ba; exp_bg[t] = 2'(g);
  endtask

  // one clock cycle: check outputs, drive inputs, advance the model
  task automatic step(input bit v, input bit w, input int bg, input logic [1:0] ba,
                      input logic [15:0] row, input logic [9:0] col, input logic [15:0] wd);
    logic [3:0]  ec;
    logic [15:0] din;
    bit          er, any;
    int          g, t;
    req_t        e;
    @(negedge clk);
    ec = exp_cmd.exists(n) ? exp_cmd[n] : C_NOP;
    chk("cmd", 32'({ddr4_cs_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n}), 32'(ec));
    if (ec == C_PRE) begin
      chk("pre_a10", 32'(ddr4_addr[10]), 32'(1'b0));
      chk("pre_ba", 32'(ddr4_ba), 32'(exp_ba[n]));
      chk("pre_bg", 32'(ddr4_bg), 32'(exp_bg[n]));
    end else if (ec != C_NOP) begin
      chk("cmd_addr", 32'(ddr4_addr), 32'(exp_addr[n]));
      chk("cmd_ba", 32'(ddr4_ba), 32'(exp_ba[n]));
      chk("cmd_bg", 32'(ddr4_bg), 32'(exp_bg[n]));
    end
    chk("dq_oe", 32'(ddr4_dq_oe), 32'(exp_wd.exists(n) != 0));
    if (exp_wd.exists(n)) chk("dq_out", 32'(ddr4_dq_out), 32'(exp_wd[n]));
    any = 1'b0;
    for (int k = 0; k < NUM_BG; k++) if (mq[k].size() != 0) any = 1'b1;
    chk("busy", 32'(busy), 32'((n < free_at) || any));

    din        = 16'($urandom);
    req_valid  = v;
    req_write  = w;
    req_addr   = {2'($urandom), row, 2'(bg), ba, col};
    req_wdata  = wd;
    ddr4_dq_in = din;
    #1;
    er = (mq[bg].size() < DEPTH);
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_tag.exists(n) != 0));
    if (exp_tag.exists(n)) begin
      chk("rsp_bg", 32'(rsp_bg), 32'(exp_tag[n]));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(din));
    end

    if (n >= free_at) begin
      g = -1;
      for (int i = NUM_BG - 1; i >= 0; i--)
        if (mq[(rr + i) % NUM_BG].size() != 0) g = (rr + i) % NUM_BG;
      if (g >= 0) begin
        e  = mq[g].pop_front();
        rr = (g + 1) % NUM_BG;
        t  = n + 1;
        if (!(open_v[g] && open_ba[g] == e.ba && open_row[g] == e.row)) begin
          if (open_v[g]) begin
            sched(t, C_PRE, 16'h0, open_ba[g], g);
            t += T_RP;
          end
          sched(t, C_ACT, e.row, e.ba, g);
          last_act    = t;
          open_v[g]   = 1'b1;
          open_ba[g]  = e.ba;
          open_row[g] = e.row;
          t += T_RCD;
        end
        sched(t, e.wr ? C_WR : C_RD, {6'b0, e.col}, e.ba, g);
        if (e.wr) exp_wd[t + T_CWL] = e.wd;
        else      exp_tag[t + T_CL] = 2'(g);
        free_at = t + 1;
      end
    end
    if (v && er) begin
      e.wr = w; e.ba = ba; e.row = row; e.col = col; e.wd = wd;
      mq[bg].push_back(e);
    end
    n++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 0, 2'd0, 16'h0, 10'h0, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    n = 0;
    #23;
    chk("rst_cmd", 32'({ddr4_cs_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n}), 32'(C_NOP));
    chk("rst_addr", 32'(ddr4_addr), 32'h0);
    chk("rst_ba", 32'(ddr4_ba), 32'h0);
    chk("rst_bg", 32'(ddr4_bg), 32'h0);
    chk("rst_dq_out", 32'(ddr4_dq_out), 32'h0);
    chk("rst_dq_oe", 32'(ddr4_dq_oe), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
    chk("rst_rsp_bg", 32'(rsp_bg), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // closed-row write, row-hit read, row-miss read
    step(1'b1, 1'b1, 0, 2'd1, 16'h0012, 10'h020, 16'hA5A5);
    idle(14);
    step(1'b1, 1'b0, 0, 2'd1, 16'h0012, 10'h040, 16'h0);
    idle(10);
    step(1'b1, 1'b0, 0, 2'd1, 16'h0034, 10'h000, 16'h0);
    idle(16);

    // round-robin: bg3 holds the bus while bg0/bg2 requests accumulate
    step(1'b1, 1'b0, 3, 2'd0, 16'h0001, 10'h001, 16'h0);
    step(1'b1, 1'b0, 0, 2'd1, 16'h0034, 10'h010, 16'h0);
    step(1'b1, 1'b0, 2, 2'd2, 16'h0005, 10'h011, 16'h0);
    step(1'b1, 1'b0, 0, 2'd1, 16'h0034, 10'h012, 16'h0);
    step(1'b1, 1'b0, 2, 2'd2, 16'h0005, 10'h013, 16'h0);
    step(1'b1, 1'b0, 0, 2'd1, 16'h0034, 10'h014, 16'h0);
    idle(30);

    // full queue: bg0 miss in flight, fill bg1, then a 5th bg1 and a bg3 request
    step(1'b1, 1'b0, 0, 2'd1, 16'h0078, 10'h000, 16'h0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 1, 2'd0, 16'h0100, 10'(i), 16'($urandom));
    step(1'b1, 1'b1, 1, 2'd0, 16'h0100, 10'h3F, 16'hBEEF);
    step(1'b1, 1'b0, 3, 2'd0, 16'h0001, 10'h005, 16'h0);
    idle(60);

    // reset while ACT is on the bus
    last_act = -1;
    step(1'b1, 1'b1, 2, 2'd0, 16'h0099, 10'h033, 16'h5A5A);
    for (int i = 0; i < 20; i++) begin
      if (last_act >= 0 && n - 1 == last_act) break;
      idle(1);
    end
    chk("act_reached", 32'(n - 1), 32'(last_act));
    rst_n = 1'b0;
    #1;
    chk("async_rst_cmd", 32'({ddr4_cs_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n}), 32'(C_NOP));
    chk("async_rst_busy", 32'(busy), 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 2, 2'd0, 16'h0099, 10'h033, 16'h5A5A);
    idle(15);

    // randomized traffic over a small row set for a mix of hits, misses and closed rows
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 99) < 40, 1'($urandom), int'($urandom_range(0, 3)),
           2'($urandom_range(0, 1)), 16'($urandom_range(0, 2)), 10'($urandom),
           16'($urandom));
    idle(220);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
